// File: rtl/package_settings.sv
`default_nettype none
// ============================================================================
//  Module      : package_settings
//  Description : Shared datapath widths for the v9 shaping filter chain.
//  Revision    : 1.0
// ============================================================================
package package_settings;

    // Filter samples are SIZE_FILTER_DATA+1 bits wide, two's complement.
    localparam int SIZE_FILTER_DATA = 15;

endpackage : package_settings
`default_nettype wire

// File: rtl/v9_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : v9_evt_pkg
//  Description : Shared types and default constants for the v9 event controller.
//  Revision    : 1.0
// ============================================================================
package v9_evt_pkg;

    import package_settings::*;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ARMED  = 3'd2,
        PEAK   = 3'd3,
        REPORT = 3'd4,
        DEAD   = 3'd5
    } evt_state_t;

    typedef logic signed [SIZE_FILTER_DATA:0] sample_t;

    localparam int C_SETTLE_CYCLES_DEF = 64;
    localparam int C_PEAK_WINDOW_DEF   = 16;
    localparam int C_DEAD_CYCLES_DEF   = 32;
    localparam int C_TS_W_DEF          = 32;
    localparam int C_CNT_W_DEF         = 16;

endpackage : v9_evt_pkg
`default_nettype wire

// File: rtl/v9_peak_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : v9_peak_tracker
//  Description : Holds the running peak amplitude and its timestamp.
//  Revision    : 1.0
// ============================================================================
module v9_peak_tracker
    import v9_evt_pkg::*;
#(
    parameter int TS_W = C_TS_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            update,
    input  sample_t         sample,
    input  logic [TS_W-1:0] ts,
    output sample_t         amp,
    output logic [TS_W-1:0] peak_ts
);

    sample_t         r_amp;
    logic [TS_W-1:0] r_peak_ts;

    // Strict greater-than keeps the earliest of equal maxima.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_amp     <= '0;
            r_peak_ts <= '0;
        end else if (load) begin
            r_amp     <= sample;
            r_peak_ts <= ts;
        end else if (update && (sample > r_amp)) begin
            r_amp     <= sample;
            r_peak_ts <= ts;
        end
    end

    assign amp     = r_amp;
    assign peak_ts = r_peak_ts;

endmodule : v9_peak_tracker
`default_nettype wire

// File: rtl/v9_filter_evt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : v9_filter_evt_ctrl
//  Description : Turns the v9 filter stream into peak events with dead time.
//  Revision    : 1.0
// ============================================================================
module v9_filter_evt_ctrl
    import v9_evt_pkg::*;
#(
    parameter int SETTLE_CYCLES = C_SETTLE_CYCLES_DEF,
    parameter int PEAK_WINDOW   = C_PEAK_WINDOW_DEF,
    parameter int DEAD_CYCLES   = C_DEAD_CYCLES_DEF,
    parameter int TS_W          = C_TS_W_DEF,
    parameter int CNT_W         = C_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  sample_t          threshold,
    input  sample_t          filter_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output sample_t          evt_amp,
    output logic [TS_W-1:0]  evt_time,
    output logic             busy,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] lost_count
);

    localparam int C_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int C_WIN_W    = (PEAK_WINDOW > 1)   ? $clog2(PEAK_WINDOW)   : 1;
    localparam int C_DEAD_W   = (DEAD_CYCLES > 1)   ? $clog2(DEAD_CYCLES)   : 1;

    evt_state_t          r_state;
    logic                r_prev_above;
    logic                r_stop_pending;
    logic                r_evt_valid;
    logic [TS_W-1:0]     r_ts;
    logic [C_SETTLE_W-1:0] r_settle_cnt;
    logic [C_WIN_W-1:0]  r_win_cnt;
    logic [C_DEAD_W-1:0] r_dead_cnt;
    logic [CNT_W-1:0]    r_evt_count;
    logic [CNT_W-1:0]    r_lost_count;

    logic w_above;
    logic w_cross;
    logic w_handshake;
    logic w_load;
    logic w_update;

    assign w_above     = (filter_data > threshold);
    assign w_cross     = w_above & ~r_prev_above;
    assign w_handshake = r_evt_valid & evt_ready;
    assign w_load      = (r_state == ARMED) & enable & w_cross;
    assign w_update    = (r_state == PEAK);

    v9_peak_tracker #(
        .TS_W    (TS_W)
    ) u_peak_tracker (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .update  (w_update),
        .sample  (filter_data),
        .ts      (r_ts),
        .amp     (evt_amp),
        .peak_ts (evt_time)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_prev_above   <= 1'b0;
            r_stop_pending <= 1'b0;
            r_evt_valid    <= 1'b0;
            r_ts           <= '0;
            r_settle_cnt   <= '0;
            r_win_cnt      <= '0;
            r_dead_cnt     <= '0;
            r_evt_count    <= '0;
            r_lost_count   <= '0;
        end else begin
            r_prev_above <= (r_state == IDLE) ? 1'b0 : w_above;

            if (r_state != IDLE) begin
                r_ts <= r_ts + TS_W'(1);
            end

            // A crossing on the DEAD-to-ARMED edge is still seen in DEAD, so it is lost.
            if (((r_state == REPORT) || (r_state == DEAD)) && w_cross &&
                (r_lost_count != {CNT_W{1'b1}})) begin
                r_lost_count <= r_lost_count + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state      <= SETTLE;
                        r_ts         <= '0;
                        r_settle_cnt <= C_SETTLE_W'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (r_settle_cnt == '0) begin
                        r_state <= ARMED;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - C_SETTLE_W'(1);
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_cross) begin
                        if (PEAK_WINDOW == 1) begin
                            r_state     <= REPORT;
                            r_evt_valid <= 1'b1;
                        end else begin
                            r_state   <= PEAK;
                            r_win_cnt <= C_WIN_W'(PEAK_WINDOW - 1);
                        end
                    end
                end
                PEAK: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (r_win_cnt == C_WIN_W'(1)) begin
                        r_state     <= REPORT;
                        r_evt_valid <= 1'b1;
                    end else begin
                        r_win_cnt <= r_win_cnt - C_WIN_W'(1);
                    end
                end
                REPORT: begin
                    // Remember a disable seen while waiting so the handshake ends in IDLE.
                    if (!enable) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_handshake) begin
                        r_evt_valid    <= 1'b0;
                        r_stop_pending <= 1'b0;
                        if (r_evt_count != {CNT_W{1'b1}}) begin
                            r_evt_count <= r_evt_count + CNT_W'(1);
                        end
                        if (!enable || r_stop_pending) begin
                            r_state <= IDLE;
                        end else begin
                            r_state    <= DEAD;
                            r_dead_cnt <= C_DEAD_W'(DEAD_CYCLES - 1);
                        end
                    end
                end
                DEAD: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (r_dead_cnt == '0) begin
                        r_state <= ARMED;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - C_DEAD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid  = r_evt_valid;
    assign busy       = (r_state != IDLE);
    assign evt_count  = r_evt_count;
    assign lost_count = r_lost_count;

endmodule : v9_filter_evt_ctrl
`default_nettype wire

// File: tb/tb_v9_filter_evt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_v9_filter_evt_ctrl
//  Description : Directed self-checking bench for v9_filter_evt_ctrl.
//  Revision    : 1.0
// ============================================================================
module tb_v9_filter_evt_ctrl;

    import package_settings::*;

    localparam int DW = SIZE_FILTER_DATA + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic signed [DW-1:0] threshold;
    logic signed [DW-1:0] filter_data;
    logic                 evt_valid;
    logic                 evt_ready;
    logic signed [DW-1:0] evt_amp;
    logic [31:0]          evt_time;
    logic                 busy;
    logic [15:0]          evt_count;
    logic [15:0]          lost_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int base     = 0;
    int exp_ts   = 0;

    v9_filter_evt_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .threshold   (threshold),
        .filter_data (filter_data),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_amp     (evt_amp),
        .evt_time    (evt_time),
        .busy        (busy),
        .evt_count   (evt_count),
        .lost_count  (lost_count)
    );

    always #5 clk = ~clk;

    // The sample d is taken at the next rising edge; outputs are read 1ns later.
    task automatic drive_tick(input int d);
        filter_data = DW'(d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_n(input int n, input int d);
        for (int i = 0; i < n; i++) drive_tick(d);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; evt_ready = 1'b0;
        threshold = '0; filter_data = '0;
        drive_n(3, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_amp", evt_amp, 0);
        check("rst_time", evt_time, 0);
        check("rst_evt_count", evt_count, 0);
        check("rst_lost_count", lost_count, 0);

        // Test 1: settle window, then basic event.
        reset = 1'b1; threshold = DW'(100);
        drive_tick(0);
        check("idle_busy", busy, 0);
        enable = 1'b1;
        drive_tick(0);
        base = cyc;
        check("settle_busy", busy, 1);
        drive_n(59, 0);
        drive_tick(500);
        drive_n(3, 0);
        drive_tick(500);
        drive_n(5, 0);
        drive_tick(50);
        drive_tick(120);
        drive_tick(300);
        drive_tick(250);
        drive_tick(90);
        drive_n(11, 0);
        check("t1_valid_early", evt_valid, 0);
        drive_tick(0);
        check("t1_valid", evt_valid, 1);
        check("t1_amp", evt_amp, 300);
        check("t1_time", evt_time, 71);
        evt_ready = 1'b1;
        drive_tick(0);
        evt_ready = 1'b0;
        check("t1_valid_drop", evt_valid, 0);
        check("t1_evt_count", evt_count, 1);

        // Test 2: crossing on the dead-to-armed edge is lost; backpressure.
        drive_n(31, 0);
        drive_tick(150);
        check("t2_dead_edge_lost", lost_count, 1);
        drive_tick(150);
        drive_n(20, 0);
        check("t2_dead_edge_no_trig", evt_valid, 0);
        drive_tick(400);
        exp_ts = cyc - base - 1;
        drive_n(14, 0);
        check("t2_valid_early", evt_valid, 0);
        drive_tick(0);
        check("t2_valid", evt_valid, 1);
        for (int i = 0; i < 200; i++) drive_tick((i == 20 || i == 80 || i == 140) ? 500 : 0);
        check("t2_hold_valid", evt_valid, 1);
        check("t2_hold_amp", evt_amp, 400);
        check("t2_hold_time", evt_time, 64'(exp_ts));
        check("t2_lost", lost_count, 4);
        check("t2_count_hold", evt_count, 1);
        evt_ready = 1'b1;
        drive_tick(0);
        evt_ready = 1'b0;
        check("t2_evt_count", evt_count, 2);

        // Test 3: re-arm exactly after dead time, equal maxima keep the first.
        drive_n(32, 0);
        drive_tick(120);
        drive_tick(200);
        exp_ts = cyc - base - 1;
        drive_tick(150);
        drive_tick(200);
        drive_n(11, 0);
        check("t3_valid_early", evt_valid, 0);
        drive_tick(0);
        check("t3_valid", evt_valid, 1);
        check("t3_amp", evt_amp, 200);
        check("t3_time_first", evt_time, 64'(exp_ts));
        check("t3_lost", lost_count, 4);
        evt_ready = 1'b1;
        drive_tick(0);
        evt_ready = 1'b0;
        check("t3_evt_count", evt_count, 3);

        // Test 4: negative threshold and samples.
        threshold = -DW'(50);
        drive_n(40, -100);
        drive_tick(-20);
        exp_ts = cyc - base - 1;
        drive_n(14, -100);
        check("t4_valid_early", evt_valid, 0);
        drive_tick(-100);
        check("t4_valid", evt_valid, 1);
        check("t4_amp", evt_amp, -20);
        check("t4_time", evt_time, 64'(exp_ts));
        evt_ready = 1'b1;
        drive_tick(-100);
        evt_ready = 1'b0;
        check("t4_evt_count", evt_count, 4);

        // Test 5a: disable mid-PEAK discards the event.
        drive_n(40, -100);
        drive_tick(-20);
        drive_tick(-10);
        drive_tick(-5);
        enable = 1'b0;
        drive_tick(-100);
        check("t5_peak_abort_busy", busy, 0);
        drive_n(20, -100);
        check("t5_peak_abort_valid", evt_valid, 0);
        check("t5_peak_abort_count", evt_count, 4);

        // Test 5b: disable during REPORT, event still completes then IDLE.
        enable = 1'b1;
        drive_tick(-100);
        base = cyc;
        drive_n(69, -100);
        drive_tick(-20);
        drive_n(14, -100);
        check("t5_valid_early", evt_valid, 0);
        drive_tick(-100);
        check("t5_valid", evt_valid, 1);
        check("t5_time_restart", evt_time, 69);
        enable = 1'b0;
        drive_n(5, -100);
        check("t5_report_busy", busy, 1);
        check("t5_report_valid", evt_valid, 1);
        evt_ready = 1'b1;
        drive_tick(-100);
        evt_ready = 1'b0;
        check("t5_hs_count", evt_count, 5);
        check("t5_hs_valid", evt_valid, 0);
        check("t5_hs_idle", busy, 0);
        drive_tick(-100);
        check("t5_stay_idle", busy, 0);

        // Test 6: reset while an event is pending in REPORT.
        enable = 1'b1;
        drive_tick(-100);
        base = cyc;
        drive_n(69, -100);
        drive_tick(30);
        drive_tick(40);
        drive_n(13, -100);
        drive_tick(-100);
        check("t6_valid", evt_valid, 1);
        check("t6_amp_signed", evt_amp, 40);
        check("t6_time", evt_time, 70);
        check("t6_lost_pre", lost_count, 4);
        enable = 1'b0;
        reset = 1'b0;
        drive_tick(-100);
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_evt_count", evt_count, 0);
        check("t6_rst_lost_count", lost_count, 0);
        check("t6_rst_amp", evt_amp, 0);
        check("t6_rst_time", evt_time, 0);
        reset = 1'b1;
        drive_tick(-100);
        check("t6_post_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_v9_filter_evt_ctrl
`default_nettype wire
